drop_timer: RTL and testbench
=============================

DROP_TIMER -- requirements
Module: drop_timer

Interface
REQ-001 SHALL have parameter CNT_W, default 26: width of the period counter and of all period parameters.
REQ-002 SHALL have parameter EASY_PERIOD, default 50000000: base drop period in Clk cycles for Easy.
REQ-003 SHALL have parameter MEDIUM_PERIOD, default 25000000: base drop period for Medium.
REQ-004 SHALL have parameter HARD_PERIOD, default 12500000: base drop period for Hard.
REQ-005 SHALL have parameter SOFT_PERIOD, default 2500000: period cap while SoftDrop is held.
REQ-006 SHALL have parameter LEVEL_STEP, default 2500000: period reduction per level.
REQ-007 SHALL have parameter MIN_PERIOD, default 2500000: floor of the level-adjusted period, and SHALL be at least 1.
REQ-008 SHALL have port Clk, input, 1 bit: single clock, all state on the rising edge.
REQ-009 SHALL have port Resetn, input, 1 bit: asynchronous active-low reset.
REQ-010 SHALL have port mode, input, 2 bits: game mode; 2'b01 = PLAY, all other values = not playing.
REQ-011 SHALL have port difdisplay, input, 2 bits: difficulty from the home-screen selector; 2'b00 Easy, 2'b01 Medium, 2'b10 Hard, 2'b11 treated as Easy.
REQ-012 SHALL have port SoftDrop, input, 1 bit: level signal, high while the player holds the down key.
REQ-013 SHALL have port LineClr, input, 1 bit: one-cycle pulse per cleared line.
REQ-014 SHALL have port drop_tick, output, 1 bit: one-cycle pulse commanding the active piece to fall one row.
REQ-015 SHALL have port level, output, 4 bits: current level, 0 to 15.

Function
REQ-016 SHALL implement an FSM with states IDLE, LOAD and RUN.
REQ-017 SHALL go from IDLE to LOAD when mode==PLAY.
REQ-018 LOAD SHALL last one cycle and SHALL latch the base period from difdisplay, clear the counter, clear level and clear the line count, then go to RUN.
REQ-019 In RUN, changes on difdisplay SHALL be ignored until the next LOAD.
REQ-020 From any state, mode!=PLAY SHALL force IDLE on the next edge; the counter SHALL be cleared, drop_tick SHALL be 0, and level SHALL hold its value.
REQ-021 SHALL compute lvl_period = max(base - level*LEVEL_STEP, MIN_PERIOD), using saturating subtraction with no underflow.
REQ-022 SHALL compute eff_period as min(lvl_period, SOFT_PERIOD) while SoftDrop=1, and as lvl_period otherwise.
REQ-023 In RUN, the counter SHALL increment every cycle; when counter >= eff_period-1, drop_tick SHALL be 1 for that cycle and the counter SHALL return to 0.
REQ-024 The first tick after LOAD SHALL occur eff_period cycles after entry to RUN.
REQ-025 If SoftDrop rises while counter >= new eff_period-1, the tick SHALL occur in that same cycle.
REQ-026 drop_tick SHALL never be high on two consecutive cycles unless eff_period==1.
REQ-027 Each LineClr pulse in RUN SHALL increment a 0..9 line count; on the 10th pulse the count SHALL wrap to 0 and level SHALL increment, saturating at 15.
REQ-028 LineClr outside RUN SHALL be ignored.
REQ-029 When LineClr and a tick occur in the same cycle, both SHALL take effect, and the new level SHALL apply to the period from the next cycle.

Reset
REQ-030 Resetn=0 SHALL immediately force state IDLE, counter 0, line count 0, level 0, drop_tick 0 and latched base EASY_PERIOD, independent of Clk.
REQ-031 Reset asserted mid-RUN SHALL abort the period in progress with no pending tick.

Configuration
REQ-032 With macro DROP_TIMER_LEVELUP_EN defined, the level and line-count logic of REQ-027 to REQ-029 SHALL be present.
REQ-033 Without DROP_TIMER_LEVELUP_EN, level SHALL be tied to 0, LineClr SHALL be ignored, and lvl_period SHALL equal base.

Verification (sim params: EASY 8, MEDIUM 4, HARD 2, SOFT 1, LEVEL_STEP 1, MIN 2)
REQ-034 Bench SHALL cover: difdisplay=00, mode 00->01 -> LOAD 1 cycle, then drop_tick every 8 cycles, first tick on the 8th RUN cycle.
REQ-035 Bench SHALL cover: difdisplay=10 at LOAD, then switched to 00 mid-RUN -> period stays 2.
REQ-036 Bench SHALL cover: Medium, SoftDrop held 5 cycles -> drop_tick every cycle while held, period 4 on release with the counter continuing.
REQ-037 Bench SHALL cover: Easy, 10 LineClr pulses -> level=1 and period 7; 70 further pulses -> level 8 and period 2 at the floor; 100 more pulses -> level saturates at 15 with period 2.
REQ-038 Bench SHALL cover: Resetn pulsed low for less than 1 Clk period mid-RUN -> level=0, no tick, FSM in IDLE; mode 01 -> fresh LOAD.
REQ-039 Bench SHALL cover: build without DROP_TIMER_LEVELUP_EN, 20 LineClr pulses -> level stays 0 and period stays 8.

Source files
------------

// File: rtl/drop_timer.sv
// Drop-period timer: picks a fall period from difficulty, level and soft-drop, and pulses drop_tick.
// Optional level-up logic is compiled in with `define DROP_TIMER_LEVELUP_EN.
module drop_timer #(
  parameter int CNT_W         = 26,
  parameter int EASY_PERIOD   = 50000000,
  parameter int MEDIUM_PERIOD = 25000000,
  parameter int HARD_PERIOD   = 12500000,
  parameter int SOFT_PERIOD   = 2500000,
  parameter int LEVEL_STEP    = 2500000,
  parameter int MIN_PERIOD    = 2500000
) (
  input  logic       Clk,
  input  logic       Resetn,
  input  logic [1:0] mode,
  input  logic [1:0] difdisplay,
  input  logic       SoftDrop,
  input  logic       LineClr,
  output logic       drop_tick,
  output logic [3:0] level
);

  // state | meaning
  // IDLE  | not playing, counter held at 0, level held
  // LOAD  | one cycle: latch base period, clear counter/level/line count
  // RUN   | counting, drop_tick on terminal count
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [1:0]       PLAY     = 2'b01;
  localparam logic [CNT_W-1:0] EASY_P   = CNT_W'(EASY_PERIOD);
  localparam logic [CNT_W-1:0] MEDIUM_P = CNT_W'(MEDIUM_PERIOD);
  localparam logic [CNT_W-1:0] HARD_P   = CNT_W'(HARD_PERIOD);
  localparam logic [CNT_W-1:0] SOFT_P   = CNT_W'(SOFT_PERIOD);

  state_t           state;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lvl_period;
  logic [CNT_W-1:0] eff_period;
  logic [CNT_W:0]   cnt_p1;
  logic             playing;
  logic             hit;

  assign playing = (mode == PLAY);

`ifdef DROP_TIMER_LEVELUP_EN
  localparam logic [CNT_W+3:0] STEP_P = (CNT_W+4)'(LEVEL_STEP);
  localparam logic [CNT_W-1:0] MIN_P  = CNT_W'(MIN_PERIOD);

  logic [3:0]       level_r;
  logic [3:0]       line_cnt;
  logic [CNT_W+3:0] dec;

  always_comb begin
    dec        = {{CNT_W{1'b0}}, level_r} * STEP_P;
    lvl_period = '0;
    if (dec < {4'b0000, base})
      lvl_period = base - dec[CNT_W-1:0];
    if (lvl_period < MIN_P)
      lvl_period = MIN_P;
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      level_r  <= 4'd0;
      line_cnt <= 4'd0;
    end else if (playing && state == LOAD) begin
      level_r  <= 4'd0;
      line_cnt <= 4'd0;
    end else if (playing && state == RUN && LineClr) begin
      if (line_cnt == 4'd9) begin
        line_cnt <= 4'd0;
        if (level_r != 4'd15)
          level_r <= level_r + 4'd1;
      end else begin
        line_cnt <= line_cnt + 4'd1;
      end
    end
  end

  assign level = level_r;
`else
  logic unused_lineclr;
  assign unused_lineclr = LineClr;
  assign lvl_period     = base;
  assign level          = 4'd0;
`endif

  always_comb begin
    eff_period = lvl_period;
    if (SoftDrop && lvl_period > SOFT_P)
      eff_period = SOFT_P;
  end

  // counter+1 >= eff_period avoids underflow of eff_period-1
  assign cnt_p1    = {1'b0, cnt} + (CNT_W+1)'(1);
  assign hit       = (cnt_p1 >= {1'b0, eff_period});
  assign drop_tick = (state == RUN) && playing && hit;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      cnt   <= '0;
      base  <= EASY_P;
    end else if (!playing) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= LOAD;
          cnt   <= '0;
        end
        LOAD: begin
          case (difdisplay)
            2'b01:   base <= MEDIUM_P;
            2'b10:   base <= HARD_P;
            default: base <= EASY_P;
          endcase
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          if (hit)
            cnt <= '0;
          else
            cnt <= cnt + CNT_W'(1);
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drop_timer.sv
// Scoreboard bench for drop_timer: expected tick cycles are queued as stimulus is applied
// and popped when drop_tick fires.
module tb_drop_timer;
  logic       Clk = 1'b0;
  logic       Resetn = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [1:0] difdisplay = 2'b00;
  logic       SoftDrop = 1'b0;
  logic       LineClr = 1'b0;
  logic       drop_tick;
  logic [3:0] level;

  int     n_checks = 0;
  int     n_fail = 0;
  longint cyc = 0;
  longint exp_q[$];
  bit     mon_en = 1'b0;

  drop_timer #(
    .CNT_W(8), .EASY_PERIOD(8), .MEDIUM_PERIOD(4), .HARD_PERIOD(2),
    .SOFT_PERIOD(1), .LEVEL_STEP(1), .MIN_PERIOD(2)
  ) dut (
    .Clk(Clk), .Resetn(Resetn), .mode(mode), .difdisplay(difdisplay),
    .SoftDrop(SoftDrop), .LineClr(LineClr), .drop_tick(drop_tick), .level(level)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(string tag, longint got, longint want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  always @(negedge Clk) begin
    if (mon_en) begin
      if (drop_tick) begin
        if (exp_q.size() == 0) check("unexpected_tick", cyc, -1);
        else check("tick_cycle", cyc, exp_q.pop_front());
      end
      while (exp_q.size() > 0 && exp_q[0] < cyc)
        check("missed_tick", cyc, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_until(longint t);
    while (cyc < t) step();
  endtask

  task automatic expect_ticks(longint first, int p, int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + longint'(i * p));
  endtask

  task automatic drained(string tag);
    check(tag, exp_q.size(), 0);
  endtask

  // returns the cycle index of RUN cycle 1
  task automatic restart(input logic [1:0] dif, output longint r);
    mode = 2'b00;
    step();
    mode = 2'b01;
    difdisplay = dif;
    r = cyc + 2;
  endtask

  task automatic pulse_lines(int n);
    mon_en = 1'b0;
    exp_q.delete();
    repeat (n) begin
      LineClr = 1'b1;
      step();
      LineClr = 1'b0;
      step();
    end
  endtask

  task automatic measure(string tag, int p);
    longint t = -1;
    mon_en = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 40 && t < 0; i++) begin
      @(negedge Clk);
      if (drop_tick) t = cyc;
    end
    if (t < 0) begin
      check({tag, "_sync"}, 0, 1);
      return;
    end
    #1;
    expect_ticks(t + p, p, 3);
    mon_en = 1'b1;
    wait_until(t + 3 * p + 1);
    drained(tag);
  endtask

  initial begin
    longint r;
    longint k;
    #3;
    check("rst_level", level, 0);
    check("rst_tick", drop_tick, 0);
    #20 Resetn = 1'b1;
    step();
    mon_en = 1'b1;
    repeat (6) step();
    drained("idle_quiet");

    restart(2'b00, r);
    expect_ticks(r + 7, 8, 4);
    wait_until(r + 32);
    drained("easy");

    restart(2'b10, r);
    expect_ticks(r + 1, 2, 8);
    wait_until(r + 4);
    difdisplay = 2'b00;
    wait_until(r + 16);
    drained("hard_ignore_dif");

    restart(2'b01, r);
    exp_q.push_back(r + 3);
    exp_q.push_back(r + 7);
    expect_ticks(r + 9, 1, 5);
    exp_q.push_back(r + 17);
    exp_q.push_back(r + 21);
    wait_until(r + 9);
    SoftDrop = 1'b1;
    wait_until(r + 14);
    SoftDrop = 1'b0;
    wait_until(r + 22);
    drained("medium_soft");

    restart(2'b00, r);
    wait_until(r);
`ifdef DROP_TIMER_LEVELUP_EN
    pulse_lines(10);
    check("level1", level, 1);
    measure("period_lvl1", 7);
    pulse_lines(70);
    check("level8", level, 8);
    measure("period_lvl8", 2);
    pulse_lines(100);
    check("level15", level, 15);
    measure("period_lvl15", 2);
`else
    pulse_lines(20);
    check("level_tied0", level, 0);
    measure("period_nolvl", 8);
`endif

    mon_en = 1'b1;
    exp_q.delete();
    k = cyc;
    #1 Resetn = 1'b0;
    #1;
    check("midrun_rst_level", level, 0);
    check("midrun_rst_tick", drop_tick, 0);
    #1 Resetn = 1'b1;
    expect_ticks(k + 9, 8, 2);
    wait_until(k + 18);
    drained("post_reset");
    check("post_reset_level", level, 0);

    mode = 2'b00;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
